// File: rtl/fetch_if.sv
// Fetch-unit bus: instruction-cache lookup, redirect request and decode-side
// handshake. The fetch unit connects as slave; its environment connects as master.
interface fetch_if;
  logic [63:0] fetch_pc;
  logic [31:0] ic_ir;
  logic        ic_valid;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        out_valid;
  logic [31:0] out_ir;
  logic [63:0] out_pc;
  logic        out_ready;

  modport master (
    input  fetch_pc, out_valid, out_ir, out_pc,
    output ic_ir, ic_valid, redirect_valid, redirect_pc, out_ready
  );

  modport slave (
    output fetch_pc, out_valid, out_ir, out_pc,
    input  ic_ir, ic_valid, redirect_valid, redirect_pc, out_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch unit: sequential PC generation with a small instruction
// buffer between the instruction cache and decode; redirects flush and re-steer.
module fetch_unit #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] entry_pc,
  fetch_if.slave      bus
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  logic [63:0]      pc_q;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;
  logic [63:0]      pc_mem [FIFO_DEPTH];
  logic [31:0]      ir_mem [FIFO_DEPTH];

  logic valid;
  logic push;
  logic pop;

  assign valid = (count != '0);
  assign pop   = valid && bus.out_ready && !bus.redirect_valid;
  // A full buffer still accepts a word when the head leaves in the same cycle.
  assign push  = bus.ic_valid && !bus.redirect_valid && ((count < DEPTH_C) || pop);

  // NOTE: all sequential state uses non-blocking (<=) assignments so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q   <= {entry_pc[63:2], 2'b00};
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (bus.redirect_valid) begin
      pc_q   <= {bus.redirect_pc[63:2], 2'b00};
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
        pc_q   <= pc_q + 64'd4;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: the entry storage has no reset; count and pointers alone decide
  // which entries are live, so stale data is never presented as valid.
  always_ff @(posedge clk) begin
    if (push && !reset) begin
      pc_mem[wr_ptr] <= pc_q;
      ir_mem[wr_ptr] <= bus.ic_ir;
    end
  end

  assign bus.fetch_pc  = pc_q;
  assign bus.out_valid = valid;
  assign bus.out_ir    = ir_mem[rd_ptr];
  assign bus.out_pc    = pc_mem[rd_ptr];

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a queue scoreboard of expected buffer
// entries plus directed scenario checks on fetch_pc and the decode outputs.
module tb_fetch_unit;

  localparam int DEPTH = 4;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] ir;
  } entry_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] entry_pc;

  fetch_if bus ();

  fetch_unit #(.FIFO_DEPTH(DEPTH)) dut (
    .clk      (clk),
    .reset    (reset),
    .entry_pc (entry_pc),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  int          tests_run    = 0;
  int          tests_failed = 0;
  entry_t      sb[$];
  logic [63:0] m_pc;

  // One clock: predict from the pre-edge inputs, advance the model, then
  // compare the DUT's visible state against it 1 time unit after the edge.
  task automatic cycle();
    bit          do_pop;
    bit          do_push;
    bit          was_reset;
    bit          was_redir;
    logic [63:0] rpc;
    logic [31:0] ir;
    bit          exp_valid;
    was_reset = reset;
    was_redir = bus.redirect_valid;
    rpc       = bus.redirect_pc;
    ir        = bus.ic_ir;
    do_pop    = !was_redir && bus.out_ready && (sb.size() != 0);
    do_push   = !was_redir && bus.ic_valid && ((sb.size() < DEPTH) || do_pop);
    @(posedge clk);
    #1;
    if (was_reset) begin
      sb.delete();
      m_pc = {entry_pc[63:2], 2'b00};
    end else if (was_redir) begin
      sb.delete();
      m_pc = {rpc[63:2], 2'b00};
    end else begin
      if (do_pop) void'(sb.pop_front());
      if (do_push) begin
        sb.push_back('{pc: m_pc, ir: ir});
        m_pc = m_pc + 64'd4;
      end
    end
    exp_valid = (sb.size() != 0);
    tests_run++;
    if (bus.fetch_pc !== m_pc) begin
      tests_failed++;
      $display("FAIL sb_fetch_pc: got %h expected %h", bus.fetch_pc, m_pc);
    end
    tests_run++;
    if (bus.out_valid !== exp_valid) begin
      tests_failed++;
      $display("FAIL sb_out_valid: got %b expected %b", bus.out_valid, exp_valid);
    end
    if (exp_valid) begin
      tests_run++;
      if (bus.out_pc !== sb[0].pc || bus.out_ir !== sb[0].ir) begin
        tests_failed++;
        $display("FAIL sb_head: got pc %h ir %h expected pc %h ir %h",
                 bus.out_pc, bus.out_ir, sb[0].pc, sb[0].ir);
      end
    end
    bus.ic_ir = $urandom;
  endtask

  task automatic redirect_to(input logic [63:0] pc);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = pc;
    cycle();
    bus.redirect_valid = 1'b0;
  endtask

  task automatic test_reset();
    logic [63:0] exp_seq [3];
    exp_seq[0] = 64'h1000;
    exp_seq[1] = 64'h1004;
    exp_seq[2] = 64'h1008;
    reset              = 1'b1;
    entry_pc           = 64'h1000;
    bus.ic_valid       = 1'b1;
    bus.out_ready      = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 64'h9990;
    cycle();
    tests_run++;
    if (bus.out_valid !== 1'b0 || bus.fetch_pc !== 64'h1000) begin
      tests_failed++;
      $display("FAIL reset_state: got valid %b pc %h expected 0 1000", bus.out_valid, bus.fetch_pc);
    end
    reset              = 1'b0;
    bus.redirect_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      tests_run++;
      if (bus.out_valid !== 1'b1 || bus.out_pc !== exp_seq[i]) begin
        tests_failed++;
        $display("FAIL startup_seq%0d: got valid %b pc %h expected 1 %h",
                 i, bus.out_valid, bus.out_pc, exp_seq[i]);
      end
    end
  endtask

  task automatic test_full();
    bus.out_ready = 1'b0;
    bus.ic_valid  = 1'b1;
    redirect_to(64'h5000);
    for (int i = 0; i < 6; i++) cycle();
    tests_run++;
    if (bus.fetch_pc !== 64'h5010 || bus.out_pc !== 64'h5000) begin
      tests_failed++;
      $display("FAIL full_freeze: got fetch_pc %h head %h expected 5010 5000", bus.fetch_pc, bus.out_pc);
    end
    bus.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) cycle();
    tests_run++;
    if (bus.fetch_pc !== 64'h5030 || bus.out_pc !== 64'h5020) begin
      tests_failed++;
      $display("FAIL full_stream: got fetch_pc %h head %h expected 5030 5020", bus.fetch_pc, bus.out_pc);
    end
  endtask

  task automatic test_miss();
    bus.out_ready = 1'b1;
    bus.ic_valid  = 1'b0;
    redirect_to(64'h2040);
    for (int i = 0; i < 10; i++) begin
      cycle();
      tests_run++;
      if (bus.fetch_pc !== 64'h2040 || bus.out_valid !== 1'b0) begin
        tests_failed++;
        $display("FAIL miss_hold%0d: got pc %h valid %b expected 2040 0", i, bus.fetch_pc, bus.out_valid);
      end
    end
    bus.ic_valid = 1'b1;
    bus.ic_ir    = 32'hDEAD_BEEF;
    bus.out_ready = 1'b0;
    cycle();
    tests_run++;
    if (bus.out_pc !== 64'h2040 || bus.out_ir !== 32'hDEAD_BEEF || bus.fetch_pc !== 64'h2044) begin
      tests_failed++;
      $display("FAIL miss_fill: got pc %h ir %h fetch %h expected 2040 deadbeef 2044",
               bus.out_pc, bus.out_ir, bus.fetch_pc);
    end
    bus.ic_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      tests_run++;
      if (bus.out_ir !== 32'hDEAD_BEEF || bus.out_pc !== 64'h2040) begin
        tests_failed++;
        $display("FAIL stall_stable%0d: got pc %h ir %h expected 2040 deadbeef", i, bus.out_pc, bus.out_ir);
      end
    end
  endtask

  task automatic test_redirect();
    bus.out_ready = 1'b0;
    bus.ic_valid  = 1'b1;
    redirect_to(64'h7000);
    for (int i = 0; i < 3; i++) cycle();
    bus.out_ready = 1'b1;
    redirect_to(64'h3007);
    tests_run++;
    if (bus.out_valid !== 1'b0 || bus.fetch_pc !== 64'h3004) begin
      tests_failed++;
      $display("FAIL redirect_flush: got valid %b pc %h expected 0 3004", bus.out_valid, bus.fetch_pc);
    end
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 64'h4000;
    cycle();
    bus.redirect_pc    = 64'h4102;
    cycle();
    bus.redirect_valid = 1'b0;
    tests_run++;
    if (bus.fetch_pc !== 64'h4100 || bus.out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL redirect_b2b: got pc %h valid %b expected 4100 0", bus.fetch_pc, bus.out_valid);
    end
  endtask

  task automatic test_wrap();
    bus.ic_valid  = 1'b0;
    bus.out_ready = 1'b0;
    redirect_to(64'hFFFF_FFFF_FFFF_FFFC);
    bus.ic_valid = 1'b1;
    cycle();
    tests_run++;
    if (bus.fetch_pc !== 64'h0 || bus.out_pc !== 64'hFFFF_FFFF_FFFF_FFFC) begin
      tests_failed++;
      $display("FAIL pc_wrap: got fetch %h head %h expected 0 fffffffffffffffc", bus.fetch_pc, bus.out_pc);
    end
  endtask

  task automatic test_reset_midstream();
    bus.ic_valid  = 1'b1;
    bus.out_ready = 1'b0;
    redirect_to(64'h6000);
    for (int i = 0; i < 5; i++) cycle();
    entry_pc = 64'h8000;
    reset    = 1'b1;
    cycle();
    tests_run++;
    if (bus.out_valid !== 1'b0 || bus.fetch_pc !== 64'h8000) begin
      tests_failed++;
      $display("FAIL reset_mid: got valid %b pc %h expected 0 8000", bus.out_valid, bus.fetch_pc);
    end
    reset = 1'b0;
    cycle();
    tests_run++;
    if (bus.out_valid !== 1'b1 || bus.out_pc !== 64'h8000) begin
      tests_failed++;
      $display("FAIL reset_restart: got valid %b pc %h expected 1 8000", bus.out_valid, bus.out_pc);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      bus.ic_valid       = ($urandom_range(3) != 0);
      bus.out_ready      = ($urandom_range(2) != 0);
      bus.redirect_valid = ($urandom_range(15) == 0);
      bus.redirect_pc    = {$urandom, $urandom};
      cycle();
    end
    bus.redirect_valid = 1'b0;
  endtask

  initial begin
    reset              = 1'b1;
    entry_pc           = 64'h0;
    bus.ic_ir          = 32'h0;
    bus.ic_valid       = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 64'h0;
    bus.out_ready      = 1'b0;
    m_pc               = 64'h0;
    test_reset();
    test_full();
    test_miss();
    test_redirect();
    test_wrap();
    test_reset_midstream();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
